// File: rtl/depth_test_unit_pkg.sv
// Shared types and the depth comparison for the depth test unit.
// Holds the GL depth-function encoding, the FSM state type and the
// unsigned compare used on every read response.
package depth_pkg;

    // GL depth functions, encoded as on the depth_func_i port.
    typedef enum logic [2:0] {
        DF_NEVER    = 3'd0,
        DF_LESS     = 3'd1,
        DF_LEQUAL   = 3'd2,
        DF_GREATER  = 3'd3,
        DF_GEQUAL   = 3'd4,
        DF_EQUAL    = 3'd5,
        DF_NOTEQUAL = 3'd6,
        DF_ALWAYS   = 3'd7
    } depth_func_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_REQ = 3'd1,
        ST_RD_RSP = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESULT = 3'd4,
        ST_CLEAR  = 3'd5
    } dtu_state_t;

    // Compare width; depth words are zero-extended to this, which keeps
    // the compare unsigned for any depth width up to 32 bits.
    localparam int CMP_W = 32;

    // Fragment depth is always the left-hand operand.
    function automatic logic depth_compare(input depth_func_t   func,
                                           input logic [CMP_W-1:0] frag_z,
                                           input logic [CMP_W-1:0] stored_z);
        logic pass;
        case (func)
            DF_NEVER:    pass = 1'b0;
            DF_LESS:     pass = (frag_z <  stored_z);
            DF_LEQUAL:   pass = (frag_z <= stored_z);
            DF_GREATER:  pass = (frag_z >  stored_z);
            DF_GEQUAL:   pass = (frag_z >= stored_z);
            DF_EQUAL:    pass = (frag_z == stored_z);
            DF_NOTEQUAL: pass = (frag_z != stored_z);
            default:     pass = 1'b1;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/depth_test_unit_if.sv
// Depth buffer memory port: read request, read response and write
// channels, each a valid/ready handshake. The depth unit is the master.
interface depth_mem_if #(
    parameter int ADDR_SIZE = 32,
    parameter int Z_SIZE    = 16
);
    logic                 rd_req_valid;
    logic                 rd_req_ready;
    logic [ADDR_SIZE-1:0] rd_addr;

    logic                 rd_rsp_valid;
    logic                 rd_rsp_ready;
    logic [Z_SIZE-1:0]    rd_data;

    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [Z_SIZE-1:0]    wr_data;

    modport master (
        output rd_req_valid, rd_addr, input  rd_req_ready,
        input  rd_rsp_valid, rd_data, output rd_rsp_ready,
        output wr_valid, wr_addr, wr_data, input wr_ready
    );

    modport slave (
        input  rd_req_valid, rd_addr, output rd_req_ready,
        output rd_rsp_valid, rd_data, input  rd_rsp_ready,
        input  wr_valid, wr_addr, wr_data, output wr_ready
    );
endinterface

// File: rtl/depth_test_unit_clear_ctrl.sv
// Clear engine index counter and address generator.
// start_i rewinds the index and captures the base address; step_i moves
// to the next pixel after a write handshake. next_addr_o is the address
// of the pixel after the current one, last_o flags the final pixel.
module depth_clear_ctrl #(
    parameter int X_RES     = 640,
    parameter int Y_RES     = 480,
    parameter int ADDR_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 step_i,
    input  logic [ADDR_SIZE-1:0] base_i,
    output logic [ADDR_SIZE-1:0] next_addr_o,
    output logic                 last_o
);
    localparam int TOTAL = X_RES * Y_RES;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic [IDX_W-1:0]     idx_q;
    logic [ADDR_SIZE-1:0] base_q;

    // Pixel index and base address for the clear in progress.
    always_ff @(posedge clk_i) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of block ordering.
        if (!rst_ni) begin
            idx_q  <= '0;
            base_q <= '0;
        end else if (start_i) begin
            idx_q  <= '0;
            base_q <= base_i;
        end else if (step_i) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    assign next_addr_o = base_q + ADDR_SIZE'(idx_q) + ADDR_SIZE'(1);
    assign last_o      = (idx_q == IDX_W'(TOTAL - 1));

endmodule

// File: rtl/depth_test_unit.sv
// Per-fragment depth test with a full-buffer clear engine.
// Accepts one fragment, reads the stored depth, compares under the
// latched depth function, optionally writes the fragment depth back and
// reports pass/fail. Optional macro DEPTH_TEST_STATS_EN adds saturating
// pass/fail result counters.
module depth_test_unit
    import depth_pkg::*;
#(
    parameter int Z_SIZE       = 16,
    parameter int X_RES        = 640,
    parameter int Y_RES        = 480,
    parameter int X_PIXEL_SIZE = $clog2(X_RES),
    parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
    parameter int ADDR_SIZE    = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,

    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
    input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
    input  logic [Z_SIZE-1:0]       frag_z_i,
    input  logic [2:0]              depth_func_i,
    input  logic                    depth_write_en_i,
    input  logic [ADDR_SIZE-1:0]    base_addr_i,

    input  logic                    clear_start_i,
    input  logic [Z_SIZE-1:0]       clear_value_i,
    output logic                    clear_busy_o,
    output logic                    clear_done_o,

    depth_mem_if.master             mem,

    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic                    res_pass_o,
    output logic [X_PIXEL_SIZE-1:0] res_x_o,
    output logic [Y_PIXEL_SIZE-1:0] res_y_o
`ifdef DEPTH_TEST_STATS_EN
    ,
    output logic [31:0]             stat_pass_o,
    output logic [31:0]             stat_fail_o
`endif
);

    dtu_state_t               state_q;
    logic                     idle_q;
    logic [X_PIXEL_SIZE-1:0]  x_q;
    logic [Y_PIXEL_SIZE-1:0]  y_q;
    logic [Z_SIZE-1:0]        z_q;
    depth_func_t              func_q;
    logic                     mask_q;
    logic [ADDR_SIZE-1:0]     addr_q;
    logic                     pass_q;

    logic                     frag_fire;
    logic                     clear_accept;
    logic                     clear_step;
    logic                     clear_last;
    logic [ADDR_SIZE-1:0]     clear_next_addr;
    logic [ADDR_SIZE-1:0]     frag_addr;
    logic                     rsp_pass;

    // Ready comes from a flop; only a same-cycle clear request masks it,
    // so a clear never races a fragment into acceptance.
    assign frag_ready_o = idle_q & ~clear_start_i;
    assign frag_fire    = frag_valid_i & frag_ready_o;
    assign clear_accept = (state_q == ST_IDLE) & clear_start_i;
    assign clear_step   = (state_q == ST_CLEAR) & mem.wr_valid & mem.wr_ready;

    // Word address of the incoming fragment, wrapping in ADDR_SIZE bits.
    assign frag_addr = base_addr_i
                     + ADDR_SIZE'(frag_y_i) * ADDR_SIZE'(X_RES)
                     + ADDR_SIZE'(frag_x_i);

    assign rsp_pass = depth_compare(func_q, CMP_W'(z_q), CMP_W'(mem.rd_data));

    depth_clear_ctrl #(
        .X_RES     (X_RES),
        .Y_RES     (Y_RES),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_clear_ctrl (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (clear_accept),
        .step_i      (clear_step),
        .base_i      (base_addr_i),
        .next_addr_o (clear_next_addr),
        .last_o      (clear_last)
    );

    // Main FSM: fragment read/compare/write/result sequence and the clear
    // loop; all handshake outputs are driven from here as registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            idle_q           <= 1'b0;
            x_q              <= '0;
            y_q              <= '0;
            z_q              <= '0;
            func_q           <= DF_NEVER;
            mask_q           <= 1'b0;
            addr_q           <= '0;
            pass_q           <= 1'b0;
            mem.rd_req_valid <= 1'b0;
            mem.rd_addr      <= '0;
            mem.rd_rsp_ready <= 1'b0;
            mem.wr_valid     <= 1'b0;
            mem.wr_addr      <= '0;
            mem.wr_data      <= '0;
            res_valid_o      <= 1'b0;
            res_pass_o       <= 1'b0;
            res_x_o          <= '0;
            res_y_o          <= '0;
            clear_busy_o     <= 1'b0;
            clear_done_o     <= 1'b0;
        end else begin
            clear_done_o <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    idle_q <= 1'b1;
                    if (clear_start_i) begin
                        idle_q       <= 1'b0;
                        mem.wr_valid <= 1'b1;
                        mem.wr_addr  <= base_addr_i;
                        mem.wr_data  <= clear_value_i;
                        clear_busy_o <= 1'b1;
                        state_q      <= ST_CLEAR;
                    end else if (frag_fire) begin
                        idle_q           <= 1'b0;
                        x_q              <= frag_x_i;
                        y_q              <= frag_y_i;
                        z_q              <= frag_z_i;
                        func_q           <= depth_func_t'(depth_func_i);
                        mask_q           <= depth_write_en_i;
                        addr_q           <= frag_addr;
                        mem.rd_req_valid <= 1'b1;
                        mem.rd_addr      <= frag_addr;
                        state_q          <= ST_RD_REQ;
                    end
                end

                ST_RD_REQ: begin
                    if (mem.rd_req_ready) begin
                        mem.rd_req_valid <= 1'b0;
                        mem.rd_rsp_ready <= 1'b1;
                        state_q          <= ST_RD_RSP;
                    end
                end

                ST_RD_RSP: begin
                    if (mem.rd_rsp_valid) begin
                        mem.rd_rsp_ready <= 1'b0;
                        pass_q           <= rsp_pass;
                        if (rsp_pass && mask_q) begin
                            mem.wr_valid <= 1'b1;
                            mem.wr_addr  <= addr_q;
                            mem.wr_data  <= z_q;
                            state_q      <= ST_WRITE;
                        end else begin
                            res_valid_o  <= 1'b1;
                            res_pass_o   <= rsp_pass;
                            res_x_o      <= x_q;
                            res_y_o      <= y_q;
                            state_q      <= ST_RESULT;
                        end
                    end
                end

                ST_WRITE: begin
                    if (mem.wr_ready) begin
                        mem.wr_valid <= 1'b0;
                        res_valid_o  <= 1'b1;
                        res_pass_o   <= pass_q;
                        res_x_o      <= x_q;
                        res_y_o      <= y_q;
                        state_q      <= ST_RESULT;
                    end
                end

                ST_RESULT: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        idle_q      <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end

                ST_CLEAR: begin
                    if (mem.wr_ready) begin
                        if (clear_last) begin
                            mem.wr_valid <= 1'b0;
                            clear_busy_o <= 1'b0;
                            clear_done_o <= 1'b1;
                            idle_q       <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            mem.wr_addr  <= clear_next_addr;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DEPTH_TEST_STATS_EN
    logic res_fire;
    assign res_fire = res_valid_o & res_ready_i;

    // Saturating result counters, restarted by reset or an accepted clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_accept) begin
            stat_pass_o <= '0;
            stat_fail_o <= '0;
        end else if (res_fire) begin
            if (res_pass_o) begin
                if (stat_pass_o != '1) stat_pass_o <= stat_pass_o + 32'd1;
            end else begin
                if (stat_fail_o != '1) stat_fail_o <= stat_fail_o + 32'd1;
            end
        end
    end
`endif

endmodule
